// File: rtl/spi_ram_burst_wrapper.sv
// spi_ram_burst_wrapper: SPI slave with 2-bit command frames driving a burst-capable single-port RAM.
module spi_ram_burst_wrapper #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 8,
  parameter int AUTO_INC   = 1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic SS_n,
  input  logic MOSI,
  output logic MISO,
  output logic busy
);
  localparam int CW = $clog2(DATA_WIDTH);
  typedef enum logic [2:0] {IDLE, CMD, ADDR_WR, ADDR_RD, WRITE, READ} state_t;
  state_t state, next;
  logic cmd_hi, hold, last, in_word, wd, rd_act;
  logic [CW-1:0] cnt;
  logic [DATA_WIDTH-2:0] sh;
  logic [DATA_WIDTH-1:0] word, tx, rd_data;
  logic [ADDR_WIDTH-1:0] wr_addr, rd_addr;
  logic [DATA_WIDTH-1:0] mem [2**ADDR_WIDTH];
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= next;
  always_comb begin
    next = SS_n ? IDLE :
           state == IDLE ? CMD :
           state == CMD ? (cmd_hi ? (MOSI ? READ : ADDR_RD) : (MOSI ? WRITE : ADDR_WR)) :
           state;
    busy = state != IDLE;
    word = {sh, MOSI};
    last = cnt == CW'(DATA_WIDTH - 1);
    in_word = !SS_n && !hold && (state inside {ADDR_WR, ADDR_RD, WRITE, READ});
    wd = in_word && last;
    rd_act = !SS_n && state == READ;
  end
  // hold marks an address frame whose single word is done; trailing cycles are ignored
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      cmd_hi <= 1'b0;
      hold <= 1'b0;
      cnt <= '0;
      sh <= '0;
      tx <= '0;
      MISO <= 1'b0;
      wr_addr <= '0;
      rd_addr <= '0;
    end else begin
      cmd_hi <= state == IDLE ? MOSI : cmd_hi;
      sh <= word[DATA_WIDTH-2:0];
      cnt <= in_word && !last ? cnt + CW'(1) : '0;
      hold <= !SS_n && (hold || (wd && (state == ADDR_WR || state == ADDR_RD)));
      wr_addr <= wd && state == ADDR_WR ? word[ADDR_WIDTH-1:0] :
                 wd && state == WRITE ? wr_addr + ADDR_WIDTH'(AUTO_INC) : wr_addr;
      rd_addr <= wd && state == ADDR_RD ? word[ADDR_WIDTH-1:0] :
                 wd && state == READ ? rd_addr + ADDR_WIDTH'(AUTO_INC) : rd_addr;
      // word bit N-1 comes straight from the RAM register; tx still holds bit 0 of the previous word at cnt 0
      MISO <= rd_act && (cnt == CW'(1) ? rd_data[DATA_WIDTH-1] : tx[DATA_WIDTH-1]);
      tx <= rd_act ? (cnt == CW'(1) ? rd_data : tx) << 1 : '0;
    end
  always_ff @(posedge clk) begin
    if (wd && state == WRITE) mem[wr_addr] <= word;
    rd_data <= mem[rd_addr];
  end
endmodule

// File: tb/tb_spi_ram_burst_wrapper.sv
// tb_spi_ram_burst_wrapper: directed frame table against two configurations plus reset/abort sequences.
module tb_spi_ram_burst_wrapper;
  logic clk = 1'b0;
  logic rst_n;
  logic [1:0] ss, mosi, miso, busy;
  int n_cmp = 0, n_bad = 0;
  always #5 clk = ~clk;
  spi_ram_burst_wrapper #(.DATA_WIDTH(8), .ADDR_WIDTH(8), .AUTO_INC(1)) dut0 (
    .clk(clk), .rst_n(rst_n), .SS_n(ss[0]), .MOSI(mosi[0]), .MISO(miso[0]), .busy(busy[0]));
  spi_ram_burst_wrapper #(.DATA_WIDTH(16), .ADDR_WIDTH(10), .AUTO_INC(0)) dut1 (
    .clk(clk), .rst_n(rst_n), .SS_n(ss[1]), .MOSI(mosi[1]), .MISO(miso[1]), .busy(busy[1]));
  typedef struct {
    int dut;
    logic [1:0] cmd;
    logic [31:0] data;
    int nbits;
    logic [31:0] exp;
  } vec_t;
  vec_t vecs[28];
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask
  // frame on dut w; rx collects MISO after edges 3..2+nbits (read frames keep SS_n low one extra edge)
  task automatic frame(input int w, input logic [1:0] cmd, input logic [31:0] data, input int nbits,
                       output logic [31:0] rx);
    int last_k;
    last_k = cmd == 2'b11 ? nbits + 2 : nbits + 1;
    rx = '0;
    ss[w] = 1'b0;
    for (int k = 0; k <= last_k; k++) begin
      mosi[w] = k < 2 ? cmd[1-k] : (k < nbits + 2 ? data[nbits+1-k] : 1'b0);
      @(posedge clk);
      #1;
      if (k == 0) chk("busy_rise", 32'(busy[w]), 32'd1);
      if (k >= 3) rx = {rx[30:0], miso[w]};
    end
    ss[w] = 1'b1;
    mosi[w] = 1'b0;
    @(posedge clk);
    #1;
    chk("idle_busy", 32'(busy[w]), 32'd0);
    chk("idle_miso", 32'(miso[w]), 32'd0);
  endtask
  initial begin
    logic [31:0] rx;
    vecs = '{
      '{0, 2'b00, 32'h10, 8, 32'h0},
      '{0, 2'b01, 32'hA5, 8, 32'h0},
      '{0, 2'b10, 32'h10, 8, 32'h0},
      '{0, 2'b11, 32'h0, 8, 32'hA5},
      '{0, 2'b00, 32'hFE, 8, 32'h0},
      '{0, 2'b01, 32'h112233, 24, 32'h0},
      '{0, 2'b10, 32'hFE, 8, 32'h0},
      '{0, 2'b11, 32'h0, 24, 32'h112233},
      '{0, 2'b10, 32'h00, 8, 32'h0},
      '{0, 2'b11, 32'h0, 8, 32'h33},
      '{0, 2'b00, 32'h41, 8, 32'h0},
      '{0, 2'b01, 32'h99, 8, 32'h0},
      '{0, 2'b00, 32'h40, 8, 32'h0},
      '{0, 2'b01, 32'hC3, 8, 32'h0},
      '{0, 2'b01, 32'h16, 5, 32'h0},
      '{0, 2'b10, 32'h40, 8, 32'h0},
      '{0, 2'b11, 32'h0, 16, 32'hC399},
      '{0, 2'b01, 32'h5A, 8, 32'h0},
      '{0, 2'b10, 32'h40, 8, 32'h0},
      '{0, 2'b11, 32'h0, 16, 32'hC35A},
      '{0, 2'b01, 32'h7F, 7, 32'h0},
      '{0, 2'b01, 32'h66, 8, 32'h0},
      '{0, 2'b10, 32'h42, 8, 32'h0},
      '{0, 2'b11, 32'h0, 8, 32'h66},
      '{1, 2'b00, 32'hFC05, 16, 32'h0},
      '{1, 2'b01, 32'hBEEF1234, 32, 32'h0},
      '{1, 2'b10, 32'h0005, 16, 32'h0},
      '{1, 2'b11, 32'h0, 32, 32'h12341234}
    };
    rst_n = 1'b0;
    ss = 2'b11;
    mosi = 2'b00;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_miso", 32'(miso), 32'd0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    foreach (vecs[i]) begin
      frame(vecs[i].dut, vecs[i].cmd, vecs[i].data, vecs[i].nbits, rx);
      chk($sformatf("vec%0d", i), rx, vecs[i].exp);
    end
    frame(0, 2'b10, 32'h10, 8, rx);
    ss[0] = 1'b0;
    for (int k = 0; k < 4; k++) begin
      mosi[0] = k < 2;
      @(posedge clk);
      #1;
    end
    chk("pre_reset_miso", 32'(miso[0]), 32'd1);
    chk("pre_reset_busy", 32'(busy[0]), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("async_reset_miso", 32'(miso[0]), 32'd0);
    chk("async_reset_busy", 32'(busy[0]), 32'd0);
    ss = 2'b11;
    mosi = 2'b00;
    @(posedge clk);
    #4 rst_n = 1'b1;
    @(posedge clk);
    #1;
    frame(0, 2'b11, 32'h0, 8, rx);
    chk("post_reset_read0", rx, 32'h33);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/spi_ram_burst_wrapper.md
# spi_ram_burst_wrapper

Parametrised SPI-slave-to-single-port-RAM subsystem: a clock-synchronous SPI slave decodes 2-bit command frames and drives an internal `DATA_WIDTH × 2**ADDR_WIDTH` RAM. It generalises the fixed 8-bit/256-word SPI wrapper with configurable widths and auto-incrementing burst reads and writes that continue while `SS_n` stays low. It is the top-level memory-access block the SPI master talks to.

## Interface
- `DATA_WIDTH`, 8, word width N; the payload is N bits.
- `ADDR_WIDTH`, 8, address width; must be ≤ `DATA_WIDTH`; depth is `2**ADDR_WIDTH`.
- `AUTO_INC`, 1, when 1 the relevant address register increments after each data word.
- `clk`  in  1  single system clock; all sampling is on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `SS_n`  in  1  slave select, active low, sampled synchronously.
- `MOSI`  in  1  serial data in, MSB first.
- `MISO`  out  1  serial read data, MSB first.
- `busy`  out  1  high while a frame is in progress (FSM not IDLE).

## Operation
- Frame layout: `cmd[1:0]` followed by an N-bit payload, MSB first.
- Command `00`: set `wr_addr` = payload[ADDR_WIDTH-1:0].
- Command `01`: write data; `mem[wr_addr]` = payload.
- Command `10`: set `rd_addr` = payload[ADDR_WIDTH-1:0].
- Command `11`: read data; payload bits are ignored and `mem[rd_addr]` is shifted out on `MISO`.
- FSM states: IDLE, CMD (2 bits), ADDR_WR, ADDR_RD, WRITE, READ.
  - IDLE → CMD when `SS_n` is sampled low.
  - CMD → the state decoded from the command after bit 2.
  - Any state → IDLE on the first edge where `SS_n` is sampled high.
- Address frames (`00`, `10`) carry a single word. Extra cycles with `SS_n` low after that word are ignored until `SS_n` rises.
- Data frames (`01`, `11`) are bursts: each further group of N cycles with `SS_n` low is another word.
  - After each completed word, the address increments modulo `2**ADDR_WIDTH` when `AUTO_INC`=1 and holds when `AUTO_INC`=0.
- Abort: if `SS_n` rises mid-word, that partial word is discarded. There is no memory write and no address change for it; earlier completed words are kept.
- Reset (async):
  - `MISO`=0 and `busy`=0.
  - `wr_addr`=0, `rd_addr`=0, FSM=IDLE.
  - RAM contents are not cleared.
  - A reset during a frame aborts the frame.
- `MISO` is 0 whenever it is not driving a read bit.

## Timing
- Edge k (k=0,1,…) is the k-th rising edge at which `SS_n` is sampled low in the current frame.
- Command bits are sampled at edges 0 and 1. `busy` rises after edge 0.
- Payload of word j is sampled at edges 2+jN … 1+(j+1)N.
- Address registers and memory writes take effect no later than edge 2+(j+1)N. A read or write in a following frame observes the new value.
- Write burst: sampling of word j+1 overlaps the commit of word j. There are no gap cycles.
- Read burst (`11`):
  - For word j, `MISO` = bit N-1 of `mem[rd_addr_j]` after edge 3+jN, through bit 0 after edge 2+(j+1)N.
  - There is one turnaround cycle (edge 2) at the start of the frame only; consecutive words are back-to-back.
  - `rd_addr` advances early enough that the next word is fetched in time. Minimum N is 2.
- `SS_n` must be high for at least 1 cycle between frames.
- After the edge sampling `SS_n` high: `busy`=0, `MISO`=0.
- Simultaneous `SS_n` rise and word completion on the same edge: `SS_n` is sampled high on that edge, so the word is incomplete and is discarded.

## Test plan
- Reset:
  - Assert `rst_n` low mid read burst → `MISO`=0 and `busy`=0 immediately, without waiting for a clock.
  - After release, read addr 0 → returns the pre-reset contents.
- Single access (N=8):
  - Frame `00_00010000`, then `01_10100101`, then `10_00010000`, then `11_xxxxxxxx`.
  - → `MISO` is 1,0,1,0,0,1,0,1 after edges 3…10.
- Write burst with wrap (`AUTO_INC`=1):
  - Set wr addr 0xFE, then one `01` frame of 3 words 0x11, 0x22, 0x33.
  - → mem[0xFE]=0x11, mem[0xFF]=0x22, mem[0x00]=0x33.
- Read burst:
  - Set rd addr 0xFE, then one `11` frame of 24 data cycles.
  - → `MISO` streams 0x11, 0x22, 0x33 contiguously with no gap.
- Abort:
  - `SS_n` rises after 5 payload bits of a `01` frame → mem[wr_addr] and `wr_addr` are unchanged.
  - The next full frame writes correctly.
- Alternate parameters (`AUTO_INC`=0, N=16, ADDR_WIDTH=10):
  - A 2-word read burst repeats the same word.
  - Address payload 0xFC05 selects location 0x005.
